// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation scheduler:
// scheduler states, move word layout, piece codes and column count.
package movegen_pkg;

    localparam int NCOL    = 8;
    localparam int BOARD_W = 256;
    localparam int SQ_W    = 4;

    // Move word: {src[17:12], dst[11:6], victim[5:3], attacker[2:0]}
    localparam int MOVE_W  = 18;
    localparam int SRC_LSB = 12;
    localparam int DST_LSB = 6;
    localparam int VIC_LSB = 3;
    localparam int ATT_LSB = 0;
    localparam int SQ_IDX_W = 6;
    localparam int PIECE_W  = 3;

    // Scheduler state; exposed on a debug port so checkers can bind to it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PULSE  = 3'd2,
        WAIT   = 3'd3,
        DRAIN  = 3'd4,
        FINISH = 3'd5
    } state_e;

    // 3-bit piece codes carried in the victim/attacker fields.
    typedef enum logic [PIECE_W-1:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_e;

    // Source square of a move word.
    function automatic logic [SQ_IDX_W-1:0] mv_src(input logic [MOVE_W-1:0] m);
        return m[SRC_LSB +: SQ_IDX_W];
    endfunction

    // Destination square of a move word.
    function automatic logic [SQ_IDX_W-1:0] mv_dst(input logic [MOVE_W-1:0] m);
        return m[DST_LSB +: SQ_IDX_W];
    endfunction

endpackage

// File: rtl/movegen_scheduler_arb.sv
// Eight-way round-robin arbiter: grants the first requesting column
// strictly after ptr, wrapping 7->0. No grant at all when en is low.
module rr_arbiter8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    input  logic       en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx
);

    logic       found;
    logic [2:0] idx;

    // Scan ptr+1 .. ptr+8 (the last being ptr itself) and take the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/movegen_scheduler.sv
// One move-generation pass: snapshot the board, pulse newboard to the
// eight columns, wait for all of them to finish, then drain their move
// FIFOs round-robin into a single valid/ready stream.
//
// Output handshake: a move transfers on a cycle where mv_valid && mv_ready.
// While mv_valid is high and mv_ready low, mv_valid/mv_data/mv_col hold and
// no column FIFO is popped. A column FIFO is popped (col_mv_ready one-hot)
// only in the same cycle the output register loads its head.
module movegen_scheduler
    import movegen_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int SETTLE  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BOARD_W-1:0]      board_in,
    output logic                    busy,
    output logic [BOARD_W-1:0]      bstate,
    output logic                    newboard,
    input  logic [NCOL-1:0]         col_done,
    input  logic [NCOL-1:0]         col_mv_valid,
    input  logic [NCOL*MOVE_W-1:0]  col_mv_data,
    output logic [NCOL-1:0]         col_mv_ready,
    output logic                    mv_valid,
    output logic [MOVE_W-1:0]       mv_data,
    output logic [2:0]              mv_col,
    input  logic                    mv_ready,
    output logic                    gen_done,
    output logic                    timeout,
    output logic [7:0]              mv_count,
    output state_e                  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BOARD_W-1:0]   bstate_q, bstate_d;
    logic [2:0]           ptr_q, ptr_d;
    logic                 mv_valid_q, mv_valid_d;
    logic [MOVE_W-1:0]    mv_data_q, mv_data_d;
    logic [2:0]           mv_col_q, mv_col_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           mv_count_q, mv_count_d;

    logic                 load_en;
    logic                 accept;
    logic                 any_req;
    logic                 arb_en;
    logic [NCOL-1:0]      gnt;
    logic [2:0]           gnt_idx;
    logic [MOVE_W-1:0]    sel_data;

    assign load_en = !mv_valid_q || mv_ready;
    assign accept  = mv_valid_q && mv_ready;
    assign any_req = |col_mv_valid;
    assign arb_en  = (state_q == DRAIN) && load_en;

    rr_arbiter8 u_arb (
        .req     (col_mv_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // One-hot select of the granted column's head move.
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (gnt[c]) sel_data = col_mv_data[c*MOVE_W +: MOVE_W];
        end
    end

    // Pass sequencing, output register load/hold and move counting.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bstate_d   = bstate_q;
        ptr_d      = ptr_q;
        mv_valid_d = mv_valid_q;
        mv_data_d  = mv_data_q;
        mv_col_d   = mv_col_q;
        timeout_d  = timeout_q;
        mv_count_d = mv_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bstate_d   = board_in;
                    mv_count_d = '0;
                    timeout_d  = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                state_d = PULSE;
            end
            PULSE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                // Done from the columns wins over a coincident timeout.
                if ((wait_cnt_q >= CNT_W'(SETTLE)) && (&col_done)) begin
                    state_d = DRAIN;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            DRAIN: begin
                if (accept && (mv_count_q != 8'hFF)) begin
                    mv_count_d = mv_count_q + 8'd1;
                end
                if (|gnt) begin
                    mv_valid_d = 1'b1;
                    mv_data_d  = sel_data;
                    mv_col_d   = gnt_idx;
                    ptr_d      = gnt_idx;
                end else if (accept) begin
                    mv_valid_d = 1'b0;
                end
                if (!any_req && (!mv_valid_q || accept)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            bstate_q   <= '0;
            ptr_q      <= 3'd7;
            mv_valid_q <= 1'b0;
            mv_data_q  <= '0;
            mv_col_q   <= '0;
            timeout_q  <= 1'b0;
            mv_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bstate_q   <= bstate_d;
            ptr_q      <= ptr_d;
            mv_valid_q <= mv_valid_d;
            mv_data_q  <= mv_data_d;
            mv_col_q   <= mv_col_d;
            timeout_q  <= timeout_d;
            mv_count_q <= mv_count_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign newboard     = (state_q == PULSE);
    assign gen_done     = (state_q == FINISH);
    assign bstate       = bstate_q;
    assign col_mv_ready = gnt;
    assign mv_valid     = mv_valid_q;
    assign mv_data      = mv_data_q;
    assign mv_col       = mv_col_q;
    assign timeout      = timeout_q;
    assign mv_count     = mv_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_movegen_scheduler.sv
// Bench for movegen_scheduler: behavioural column FIFOs, a round-robin
// order model computed per pass from the FIFO contents, and a scoreboard
// of expected {column, move} words.
module tb_movegen_scheduler;
    import movegen_pkg::*;

    localparam int TMO = 1023;
    localparam int STL = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [BOARD_W-1:0]     board_in;
    logic                   busy;
    logic [BOARD_W-1:0]     bstate;
    logic                   newboard;
    logic [NCOL-1:0]        col_done;
    logic [NCOL-1:0]        col_mv_valid;
    logic [NCOL*MOVE_W-1:0] col_mv_data;
    logic [NCOL-1:0]        col_mv_ready;
    logic                   mv_valid;
    logic [MOVE_W-1:0]      mv_data;
    logic [2:0]             mv_col;
    logic                   mv_ready;
    logic                   gen_done;
    logic                   timeout;
    logic [7:0]             mv_count;
    state_e                 dbg_state;

    movegen_scheduler #(.TIMEOUT(TMO), .SETTLE(STL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .board_in     (board_in),
        .busy         (busy),
        .bstate       (bstate),
        .newboard     (newboard),
        .col_done     (col_done),
        .col_mv_valid (col_mv_valid),
        .col_mv_data  (col_mv_data),
        .col_mv_ready (col_mv_ready),
        .mv_valid     (mv_valid),
        .mv_data      (mv_data),
        .mv_col       (mv_col),
        .mv_ready     (mv_ready),
        .gen_done     (gen_done),
        .timeout      (timeout),
        .mv_count     (mv_count),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int                 total = 0;
    int                 bad   = 0;
    logic [MOVE_W-1:0]  colq[NCOL][$];
    logic [20:0]        exp_q[$];
    logic [NCOL-1:0]    pending_pop = '0;
    int                 model_ptr = 7;
    int                 serial = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_cols();
        for (int c = 0; c < NCOL; c++) begin
            col_mv_valid[c] = (colq[c].size() != 0);
            col_mv_data[c*MOVE_W +: MOVE_W] = (colq[c].size() != 0) ? colq[c][0] : '0;
        end
    endtask

    // Advance to just after the next rising edge, applying the pops seen in the last cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCOL; c++) begin
            if (pending_pop[c] && colq[c].size() != 0) void'(colq[c].pop_front());
        end
        pending_pop = '0;
        drive_cols();
    endtask

    // Observe the DUT mid-cycle.
    task automatic sample();
        @(negedge clk);
        pending_pop = col_mv_ready;
    endtask

    task automatic add_moves(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            colq[c].push_back({3'(c), 15'(serial)});
            serial++;
        end
    endtask

    // Expected emission order: repeatedly take the next non-empty column after the pointer.
    function automatic void build_expected();
        int head[NCOL];
        int rem;
        int p;
        rem = 0;
        for (int c = 0; c < NCOL; c++) begin
            head[c] = 0;
            rem += colq[c].size();
        end
        p = model_ptr;
        while (rem > 0) begin
            for (int k = 1; k <= NCOL; k++) begin
                int c;
                c = (p + k) % NCOL;
                if (head[c] < colq[c].size()) begin
                    exp_q.push_back({3'(c), colq[c][head[c]]});
                    head[c]++;
                    p = c;
                    rem--;
                    break;
                end
            end
        end
        model_ptr = p;
    endfunction

    // One full pass. D = first cycle (from the start cycle) with col_done all ones.
    task automatic do_pass(input logic [255:0] board, input int d_at, input int rdy_pct,
                           input int stall_len, input string tag,
                           output int n_acc, output int first_acc, output int last_acc);
        int  t;
        int  drain_t;
        int  f_cyc;
        int  exp_n;
        int  exp_gd;
        bit  hang;
        bit  done_seen;
        bit  seen_valid;
        bit  prev_stall;
        logic [MOVE_W-1:0] prev_data;
        logic [20:0] e;

        hang    = (d_at > 2 + TMO);
        drain_t = ((d_at > 3 + STL) ? d_at : 3 + STL) + 1;
        f_cyc   = drain_t + 1;
        exp_q.delete();
        if (!hang) build_expected();
        exp_n = exp_q.size();

        tick();
        start    = 1'b1;
        board_in = board;
        col_done = (d_at <= 0) ? 8'hFF : 8'($urandom_range(0, 254));
        mv_ready = 1'b0;
        sample();
        check($sformatf("%s_idle_busy", tag), busy, 0);

        t = 0; done_seen = 0; seen_valid = 0; prev_stall = 0; prev_data = '0;
        n_acc = 0; first_acc = -1; last_acc = -1;
        while (!done_seen && t < 3000) begin
            tick();
            t++;
            start    = 1'($urandom_range(0, 1));
            board_in = rand256();
            col_done = (t >= d_at) ? 8'hFF : 8'($urandom_range(0, 254));
            if (t >= f_cyc && t < f_cyc + stall_len) mv_ready = 1'b0;
            else mv_ready = (int'($urandom_range(1, 100)) <= rdy_pct);
            sample();
            check($sformatf("%s_busy_t%0d", tag, t), busy, 1);
            check($sformatf("%s_newboard_t%0d", tag, t), newboard, (t == 2));
            check($sformatf("%s_bstate", tag), bstate, board);
            if (t == 1) begin
                check($sformatf("%s_timeout_clr", tag), timeout, 0);
                check($sformatf("%s_count_clr", tag), mv_count, 0);
            end
            check($sformatf("%s_pop_invalid", tag), col_mv_ready & ~col_mv_valid, 0);
            check($sformatf("%s_pop_onehot", tag), ($countones(col_mv_ready) <= 1), 1);
            if (exp_n == 0) check($sformatf("%s_no_valid", tag), mv_valid, 0);
            if (prev_stall) begin
                check($sformatf("%s_hold_valid", tag), mv_valid, 1);
                check($sformatf("%s_hold_data", tag), mv_data, prev_data);
            end
            if (mv_valid && !mv_ready) check($sformatf("%s_stall_nopop", tag), col_mv_ready, 0);
            prev_stall = mv_valid && !mv_ready;
            prev_data  = mv_data;
            if (mv_valid && !seen_valid) begin
                seen_valid = 1;
                check($sformatf("%s_first_valid_cycle", tag), t, f_cyc);
            end
            if (mv_valid && mv_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_extra_move", tag), {mv_col, mv_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_move%0d", tag, n_acc), {mv_col, mv_data}, e);
                end
                n_acc++;
                if (first_acc < 0) first_acc = t;
                last_acc = t;
            end
            if (gen_done) begin
                done_seen = 1;
                if (hang) exp_gd = 3 + TMO;
                else if (exp_n > 0) exp_gd = last_acc + 1;
                else exp_gd = drain_t + 1;
                check($sformatf("%s_gen_done_cycle", tag), t, exp_gd);
                check($sformatf("%s_timeout", tag), timeout, hang);
                check($sformatf("%s_fin_valid", tag), mv_valid, 0);
                check($sformatf("%s_mv_count", tag), mv_count, (exp_n > 255) ? 255 : exp_n);
            end
        end
        check($sformatf("%s_gen_done_seen", tag), done_seen, 1);
        check($sformatf("%s_left_expected", tag), exp_q.size(), 0);
        tick();
        start = 1'b0;
        sample();
        check($sformatf("%s_after_busy", tag), busy, 0);
        check($sformatf("%s_after_gen_done", tag), gen_done, 0);
        check($sformatf("%s_after_timeout", tag), timeout, hang);
    endtask

    initial begin
        int n, fa, la, k;
        rst_n    = 1'b0;
        start    = 1'b0;
        board_in = '0;
        col_done = '0;
        mv_ready = 1'b0;
        drive_cols();

        // Reset state
        tick();
        tick();
        sample();
        check("rst_busy", busy, 0);
        check("rst_bstate", bstate, 0);
        check("rst_newboard", newboard, 0);
        check("rst_pop", col_mv_ready, 0);
        check("rst_valid", mv_valid, 0);
        check("rst_data", mv_data, 0);
        check("rst_col", mv_col, 0);
        check("rst_gen_done", gen_done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", mv_count, 0);
        check("rst_state", dbg_state, IDLE);
        tick();
        rst_n = 1'b1;
        sample();
        check("rst_release_busy", busy, 0);

        // Warm-up pass so state is non-trivial before the mid-pass reset
        add_moves(1, 2);
        add_moves(6, 1);
        do_pass(rand256(), 8, 70, 0, "warm", n, fa, la);

        // Reset in DRAIN while a move is waiting
        add_moves(0, 3);
        tick();
        start    = 1'b1;
        board_in = rand256();
        col_done = 8'hFF;
        mv_ready = 1'b1;
        sample();
        k = 0;
        while (mv_valid !== 1'b1 && k < 50) begin
            tick();
            start = 1'b0;
            sample();
            k++;
        end
        check("mid_pre_valid", mv_valid, 1);
        tick();
        mv_ready = 1'b0;
        sample();
        check("mid_second_valid", mv_valid, 1);
        check("mid_count", mv_count, 1);
        tick();
        rst_n = 1'b0;
        sample();
        tick();
        rst_n = 1'b1;
        sample();
        check("mid_rst_valid", mv_valid, 0);
        check("mid_rst_data", mv_data, 0);
        check("mid_rst_col", mv_col, 0);
        check("mid_rst_pop", col_mv_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", mv_count, 0);
        check("mid_rst_bstate", bstate, 0);
        check("mid_rst_newboard", newboard, 0);
        check("mid_rst_gen_done", gen_done, 0);
        for (int c = 0; c < NCOL; c++) colq[c].delete();
        pending_pop = '0;
        drive_cols();
        model_ptr = 7;
        for (int i = 0; i < 10; i++) begin
            tick();
            sample();
            check("mid_rst_no_gen_done", gen_done, 0);
            check("mid_rst_idle", busy, 0);
        end

        // Columns 2 and 5 with two moves each, pointer at its reset value
        add_moves(2, 2);
        add_moves(5, 2);
        do_pass(rand256(), 6, 100, 0, "rr25", n, fa, la);
        check("rr25_n", n, 4);
        check("rr25_back_to_back", la - fa, 3);

        // Stale col_done held high before start; snapshot of 256'h1
        add_moves(4, 1);
        do_pass(256'h1, 0, 100, 0, "stale", n, fa, la);
        check("stale_n", n, 1);

        // Five-cycle stall right after the first valid
        add_moves(0, 3);
        do_pass(rand256(), 5, 100, 5, "stall", n, fa, la);
        check("stall_n", n, 3);

        // Columns never all done: timeout, nothing emitted, FIFO untouched
        add_moves(6, 1);
        do_pass(rand256(), 100000, 100, 0, "tmo", n, fa, la);
        check("tmo_n", n, 0);
        check("tmo_fifo_kept", colq[6].size(), 1);

        // Done arriving on the last possible WAIT cycle beats the timeout
        do_pass(rand256(), 2 + TMO, 100, 0, "tmo_edge", n, fa, la);
        check("tmo_edge_n", n, 1);

        // 300 moves: counter saturates, stream does not
        add_moves(3, 300);
        do_pass(rand256(), 7, 100, 0, "sat", n, fa, la);
        check("sat_n", n, 300);

        // Randomised passes
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCOL; c++) begin
                if ($urandom_range(0, 1) == 1) add_moves(c, int'($urandom_range(1, 4)));
            end
            do_pass(rand256(), int'($urandom_range(0, 12)), int'($urandom_range(30, 100)),
                    int'($urandom_range(0, 3)), $sformatf("rnd%0d", r), n, fa, la);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
